// File: rtl/rggen_avalon_timeout_guard_pkg.sv
// Shared types and helpers for the Avalon-MM timeout guard.
// Also carries the Avalon response-code macros used across the register block.
// No logic; constants and a width helper only.

`ifndef RGGEN_RTL_MACROS_VH
`define RGGEN_RTL_MACROS_VH
`define RGGEN_AVALON_RESPONSE_OKAY        2'b00
`define RGGEN_AVALON_RESPONSE_SLVERR      2'b10
`define RGGEN_AVALON_RESPONSE_DECODEERROR 2'b11
`endif

package rggen_avalon_timeout_guard_pkg;

   // Transaction phases: accept, present to agent, await completion,
   // report to host, swallow a late completion after an abort.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_RESP  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Timer must hold the value TIMEOUT_CYCLES; never narrower than one bit.
   function automatic int timer_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// Saturating transaction timer; o_expire flags the last timed cycle.
// Latency: o_expire is a decode of the registered count (no input path).
// Backpressure: none; the owner decides when to clear or count.

module rggen_timeout_counter
   import rggen_avalon_timeout_guard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int            CW   = timer_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear wins; otherwise count up and stick at all-ones.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A zero budget disables expiry entirely.
   assign o_expire = (TIMEOUT_CYCLES != 0) && (count_q == LAST);

endmodule

// File: rtl/rggen_avalon_timeout_guard.sv
// Registered Avalon-MM pass-through that aborts hung agent transactions with an error.
// Latency: agent command one cycle after host accept; host completion one cycle after agent completion.
// Backpressure: host waitrequest is high whenever a transaction or a drain is outstanding.

module rggen_avalon_timeout_guard
   import rggen_avalon_timeout_guard_pkg::*;
#(
   parameter int         ADDRESS_WIDTH  = 8,
   parameter int         BUS_WIDTH      = 32,
   parameter int         TIMEOUT_CYCLES = 256,
   parameter logic [1:0] ERROR_RESPONSE = `RGGEN_AVALON_RESPONSE_SLVERR
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_host_read,
   input  logic                     i_host_write,
   input  logic [ADDRESS_WIDTH-1:0] i_host_address,
   input  logic [BUS_WIDTH/8-1:0]   i_host_byteenable,
   input  logic [BUS_WIDTH-1:0]     i_host_writedata,
   output logic                     o_host_waitrequest,
   output logic                     o_host_readdatavalid,
   output logic                     o_host_writeresponsevalid,
   output logic [1:0]               o_host_response,
   output logic [BUS_WIDTH-1:0]     o_host_readdata,
   output logic                     o_agent_read,
   output logic                     o_agent_write,
   output logic [ADDRESS_WIDTH-1:0] o_agent_address,
   output logic [BUS_WIDTH/8-1:0]   o_agent_byteenable,
   output logic [BUS_WIDTH-1:0]     o_agent_writedata,
   input  logic                     i_agent_waitrequest,
   input  logic                     i_agent_readdatavalid,
   input  logic                     i_agent_writeresponsevalid,
   input  logic [1:0]               i_agent_response,
   input  logic [BUS_WIDTH-1:0]     i_agent_readdata,
   output logic                     o_timeout
);

   state_e                   state_q,      state_d;
   logic [ADDRESS_WIDTH-1:0] address_q,    address_d;
   logic [BUS_WIDTH/8-1:0]   byteenable_q, byteenable_d;
   logic [BUS_WIDTH-1:0]     writedata_q,  writedata_d;
   logic                     write_q,      write_d;
   logic [1:0]               response_q,   response_d;
   logic [BUS_WIDTH-1:0]     readdata_q,   readdata_d;
   logic                     timeout_q,    timeout_d;
   logic                     drain_q,      drain_d;
   logic                     expire;
   logic                     completion;

   // Only the strobe matching the outstanding command kind counts.
   assign completion = write_q ? i_agent_writeresponsevalid : i_agent_readdatavalid;

   rggen_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (state_q == ST_IDLE),
      .i_enable ((state_q == ST_CMD) || (state_q == ST_RESP)),
      .o_expire (expire)
   );

   // Next-state and capture logic; a real agent event always beats expiry.
   always_comb begin
      state_d      = state_q;
      address_d    = address_q;
      byteenable_d = byteenable_q;
      writedata_d  = writedata_q;
      write_d      = write_q;
      response_d   = response_q;
      readdata_d   = readdata_q;
      timeout_d    = timeout_q;
      drain_d      = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (i_host_read || i_host_write) begin
               address_d    = i_host_address;
               byteenable_d = i_host_byteenable;
               writedata_d  = i_host_writedata;
               write_d      = i_host_write;
               state_d      = ST_CMD;
            end
         end
         ST_CMD: begin
            if (!i_agent_waitrequest) begin
               state_d = ST_RESP;
            end else if (expire) begin
               // Command withdrawn; the agent never saw it, so nothing to drain.
               response_d = ERROR_RESPONSE;
               readdata_d = '0;
               timeout_d  = 1'b1;
               drain_d    = 1'b0;
               state_d    = ST_DONE;
            end
         end
         ST_RESP: begin
            if (completion) begin
               response_d = i_agent_response;
               readdata_d = write_q ? '0 : i_agent_readdata;
               timeout_d  = 1'b0;
               drain_d    = 1'b0;
               state_d    = ST_DONE;
            end else if (expire) begin
               // Agent owns the command; its late completion must be swallowed.
               response_d = ERROR_RESPONSE;
               readdata_d = '0;
               timeout_d  = 1'b1;
               drain_d    = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = drain_q ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (completion) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured-transaction registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         address_q    <= '0;
         byteenable_q <= '0;
         writedata_q  <= '0;
         write_q      <= 1'b0;
         response_q   <= '0;
         readdata_q   <= '0;
         timeout_q    <= 1'b0;
         drain_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         byteenable_q <= byteenable_d;
         writedata_q  <= writedata_d;
         write_q      <= write_d;
         response_q   <= response_d;
         readdata_q   <= readdata_d;
         timeout_q    <= timeout_d;
         drain_q      <= drain_d;
      end
   end

   assign o_host_waitrequest        = (state_q != ST_IDLE);
   assign o_host_readdatavalid      = (state_q == ST_DONE) && !write_q;
   assign o_host_writeresponsevalid = (state_q == ST_DONE) &&  write_q;
   assign o_host_response           = (state_q == ST_DONE) ? response_q : 2'b00;
   assign o_host_readdata           = (state_q == ST_DONE) ? readdata_q : '0;
   assign o_timeout                 = (state_q == ST_DONE) && timeout_q;

   assign o_agent_read       = (state_q == ST_CMD) && !write_q;
   assign o_agent_write      = (state_q == ST_CMD) &&  write_q;
   assign o_agent_address    = address_q;
   assign o_agent_byteenable = byteenable_q;
   assign o_agent_writedata  = writedata_q;

endmodule
